// File: rtl/mips_pkg.sv
// Shared definitions for the mips front end: reset PC default, word size and fetch FSM states.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two >= 2.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full queue is allowed when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited requests to imem,
// buffers in-order responses and discards stale ones after a core redirect.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int          CW  = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          req_valid_q;
    logic          req_valid_next;

    logic          accept;
    logic          resp_keep;
    logic          push;
    logic          pop;
    logic          empty;
    logic [63:0]   head;
    logic [31:0]   tag_pc;
    logic [CW-1:0] tag_count;
    logic          tag_empty;
    logic          tag_full;
    logic          inst_q_full;
    logic          sink_unused;

    assign accept         = req_valid_q & imem_req_ready;
    assign resp_keep      = imem_resp_valid & (drop_cnt == '0);
    assign push           = resp_keep & ~redirect_valid;
    assign pop            = inst_valid & inst_ready;
    assign inst_valid     = ~empty;
    assign inst           = inst_valid ? head[31:0]  : NOP;
    assign inst_pc        = inst_valid ? head[63:32] : 32'h0;
    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc;
    assign sink_unused    = ^{tag_count, tag_empty, tag_full, inst_q_full, redirect_pc[1:0]};

    // A redirect turns every in-flight request into one to be dropped, including a
    // request accepted in the same cycle, minus a response that lands in that cycle.
    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        outstanding_next = outstanding;
        drop_next        = drop_cnt;
        count_next       = count;
        if (redirect_valid) begin
            drop_next        = outstanding - CW'(imem_resp_valid) + CW'(accept);
            outstanding_next = drop_next;
            count_next       = '0;
            fetch_pc_next    = {redirect_pc[31:2], 2'b00};
            state_next       = (drop_next != '0) ? DRAIN : RUN;
        end else begin
            if (accept) fetch_pc_next = fetch_pc + 32'(WORD_BYTES);
            outstanding_next = outstanding + CW'(accept) - CW'(imem_resp_valid);
            if (imem_resp_valid && (drop_cnt != '0)) drop_next = drop_cnt - CW'(1);
            count_next = count + CW'(push) - CW'(pop);
            if ((state == DRAIN) && (drop_next == '0)) state_next = RUN;
        end
        req_valid_next = (state_next == RUN) &&
                         (({1'b0, outstanding_next} + {1'b0, count_next}) < CAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_next;
            req_valid_q <= req_valid_next;
        end
    end

    sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_inst_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({tag_pc, imem_resp_data}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (inst_q_full)
    );

    // Each accepted request leaves its PC here; a kept response pairs with the oldest tag.
    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (accept & ~redirect_valid),
        .push_data (fetch_pc),
        .pop       (push),
        .head      (tag_pc),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

endmodule
